difftest_commit_queue: RTL and testbench

//  Multi-lane commit buffer between the core's retire stage and the difftest commit ports in SimTop.

---
 rtl/zc_difftest_pkg.sv | 42 ++++
 rtl/commit_fifo_mem.sv | 35 +++
 rtl/difftest_commit_queue.sv | 209 ++++++++++++++++++++
 tb/tb_difftest_commit_queue.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zc_difftest_pkg.sv
// Shared definitions for the difftest commit queue: entry layout, the good-trap
// opcode and helpers for building and inspecting commit entries.
package zc_difftest_pkg;

    localparam int CQ_XLEN = 64;
    localparam int CQ_ILEN = 32;

    localparam logic [CQ_ILEN-1:0] TRAP_INST = 32'h0000006b;

    typedef struct packed {
        logic [CQ_XLEN-1:0] pc;
        logic [CQ_ILEN-1:0] instr;
        logic               wen;
        logic [7:0]         wdest;
        logic               skip;
        logic [CQ_XLEN-1:0] wdata;
    } commit_entry_t;

    // x0 is hard-wired to zero, so a write to it is never reported as a GPR update.
    function automatic commit_entry_t make_entry(
        input logic [CQ_XLEN-1:0] pc,
        input logic [CQ_ILEN-1:0] instr,
        input logic               wen,
        input logic [7:0]         wdest,
        input logic               skip,
        input logic [CQ_XLEN-1:0] wdata
    );
        commit_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        e.wen   = wen & (wdest != 8'd0);
        e.wdest = wdest;
        e.skip  = skip;
        e.wdata = wdata;
        return e;
    endfunction

    function automatic logic is_trap(input commit_entry_t e);
        return e.instr == TRAP_INST;
    endfunction

endpackage

// File: rtl/commit_fifo_mem.sv
// Commit queue storage: DEPTH entries, IN_CH write ports, OUT_CH asynchronous read ports.
// Storage carries no reset; validity is tracked by the pointers in the parent.
module commit_fifo_mem
    import zc_difftest_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int IN_CH  = 2,
    parameter int OUT_CH = 2,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic [IN_CH-1:0]  i_wr_en,
    input  logic [AW-1:0]     i_wr_addr [IN_CH],
    input  commit_entry_t     i_wr_data [IN_CH],
    input  logic [AW-1:0]     i_rd_addr [OUT_CH],
    output commit_entry_t     o_rd_data [OUT_CH]
);

    commit_entry_t r_mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int k = 0; k < IN_CH; k++) begin
            if (i_wr_en[k]) begin
                r_mem[i_wr_addr[k]] <= i_wr_data[k];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < OUT_CH; j++) begin
            o_rd_data[j] = r_mem[i_rd_addr[j]];
        end
    end

endmodule

// File: rtl/difftest_commit_queue.sv
// Multi-lane in-order commit buffer between the retire stage and the difftest commit ports.
// Optional good-trap detection and freeze is built when COMMIT_TRAP_EN is defined.
module difftest_commit_queue
    import zc_difftest_pkg::*;
#(
    parameter int XLEN   = CQ_XLEN,
    parameter int ILEN   = CQ_ILEN,
    parameter int IN_CH  = 2,
    parameter int OUT_CH = 2,
    parameter int DEPTH  = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [IN_CH-1:0]       in_valid,
    output logic                   in_ready,
    input  logic [IN_CH*XLEN-1:0]  in_pc,
    input  logic [IN_CH*ILEN-1:0]  in_instr,
    input  logic [IN_CH-1:0]       in_wen,
    input  logic [IN_CH*8-1:0]     in_wdest,
    input  logic [IN_CH*XLEN-1:0]  in_wdata,
    input  logic [IN_CH-1:0]       in_skip,
    output logic [OUT_CH-1:0]      out_valid,
    output logic [OUT_CH*XLEN-1:0] out_pc,
    output logic [OUT_CH*ILEN-1:0] out_instr,
    output logic [OUT_CH-1:0]      out_wen,
    output logic [OUT_CH*8-1:0]    out_wdest,
    output logic [OUT_CH*XLEN-1:0] out_wdata,
    output logic [OUT_CH-1:0]      out_skip,
    output logic [OUT_CH*8-1:0]    out_index,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [63:0]            instr_cnt,
    output logic [63:0]            cycle_cnt,
    input  logic [XLEN-1:0]        a0_value,
    output logic                   trap_valid,
    output logic [XLEN-1:0]        trap_code,
    output logic [XLEN-1:0]        trap_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_live;
    logic [63:0]       r_instr_cnt;
    logic [63:0]       r_cycle_cnt;
    logic [OUT_CH-1:0] r_out_valid;
    commit_entry_t     r_out_ent [OUT_CH];

    logic              w_frozen;
    logic              w_trap_hit;
    logic [IN_CH-1:0]  w_push_vld;
    logic [CW-1:0]     w_npush;
    logic [CW-1:0]     w_npop;
    commit_entry_t     w_in_ent  [IN_CH];
    logic [IN_CH-1:0]  w_wr_en;
    logic [AW-1:0]     w_wr_addr [IN_CH];
    commit_entry_t     w_wr_data [IN_CH];
    logic [AW-1:0]     w_rd_addr [OUT_CH];
    commit_entry_t     w_rd_data [OUT_CH];
    logic [OUT_CH-1:0] w_take;
`ifdef COMMIT_TRAP_EN
    logic [XLEN-1:0]   w_trap_pc;
`endif

    // Readiness looks only at the registered count; a same-cycle pop earns no credit.
    assign in_ready   = r_live & ~w_frozen & (int'(r_count) <= DEPTH - IN_CH);
    assign w_push_vld = in_valid & {IN_CH{in_ready}};

    always_comb begin
        for (int i = 0; i < IN_CH; i++) begin
            w_in_ent[i] = make_entry(in_pc[i*XLEN +: XLEN], in_instr[i*ILEN +: ILEN],
                                     in_wen[i], in_wdest[i*8 +: 8], in_skip[i],
                                     in_wdata[i*XLEN +: XLEN]);
        end
    end

    // Compaction: the k-th valid lane (ascending) goes to write port k at wr_ptr+k.
    always_comb begin
        w_npush = '0;
        for (int k = 0; k < IN_CH; k++) begin
            w_wr_en[k]   = 1'b0;
            w_wr_data[k] = '0;
            w_wr_addr[k] = r_wr_ptr + AW'(k);
        end
        for (int i = 0; i < IN_CH; i++) begin
            if (w_push_vld[i]) begin
                for (int k = 0; k < IN_CH; k++) begin
                    if (int'(w_npush) == k) begin
                        w_wr_en[k]   = 1'b1;
                        w_wr_data[k] = w_in_ent[i];
                    end
                end
                w_npush = w_npush + CW'(1);
            end
        end
    end

    // Oldest entries fill lanes from 0; a trap entry ends the group at its own lane.
    always_comb begin
        w_npop     = '0;
        w_take     = '0;
        w_trap_hit = 1'b0;
`ifdef COMMIT_TRAP_EN
        w_trap_pc  = '0;
`endif
        for (int j = 0; j < OUT_CH; j++) begin
            w_rd_addr[j] = r_rd_ptr + AW'(j);
            if (!w_frozen && !w_trap_hit && int'(r_count) > j) begin
                w_take[j] = 1'b1;
                w_npop    = w_npop + CW'(1);
`ifdef COMMIT_TRAP_EN
                if (is_trap(w_rd_data[j])) begin
                    w_trap_hit = 1'b1;
                    w_trap_pc  = w_rd_data[j].pc;
                end
`endif
            end
        end
    end

    commit_fifo_mem #(
        .DEPTH  (DEPTH),
        .IN_CH  (IN_CH),
        .OUT_CH (OUT_CH)
    ) u_mem (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_live      <= 1'b0;
            r_instr_cnt <= '0;
            r_cycle_cnt <= '0;
            r_out_valid <= '0;
            for (int j = 0; j < OUT_CH; j++) begin
                r_out_ent[j] <= '0;
            end
        end else begin
            r_live      <= 1'b1;
            r_wr_ptr    <= r_wr_ptr + w_npush[AW-1:0];
            r_rd_ptr    <= r_rd_ptr + w_npop[AW-1:0];
            r_count     <= r_count + w_npush - w_npop;
            r_out_valid <= w_take;
            for (int j = 0; j < OUT_CH; j++) begin
                r_out_ent[j] <= w_take[j] ? w_rd_data[j] : '0;
            end
            if (!w_frozen) begin
                r_instr_cnt <= r_instr_cnt + 64'(w_npop);
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
            end
        end
    end

    for (genvar j = 0; j < OUT_CH; j++) begin : g_out
        assign out_pc[j*XLEN +: XLEN]    = r_out_ent[j].pc;
        assign out_instr[j*ILEN +: ILEN] = r_out_ent[j].instr;
        assign out_wen[j]                = r_out_ent[j].wen;
        assign out_wdest[j*8 +: 8]       = r_out_ent[j].wdest;
        assign out_wdata[j*XLEN +: XLEN] = r_out_ent[j].wdata;
        assign out_skip[j]               = r_out_ent[j].skip;
        assign out_index[j*8 +: 8]       = 8'(j);
    end

    assign out_valid = r_out_valid;
    assign occupancy = r_count;
    assign instr_cnt = r_instr_cnt;
    assign cycle_cnt = r_cycle_cnt;

`ifdef COMMIT_TRAP_EN
    logic            r_trap_valid;
    logic [XLEN-1:0] r_trap_code;
    logic [XLEN-1:0] r_trap_pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_trap_valid <= 1'b0;
            r_trap_code  <= '0;
            r_trap_pc    <= '0;
        end else if (w_trap_hit) begin
            r_trap_valid <= 1'b1;
            r_trap_code  <= a0_value;
            r_trap_pc    <= w_trap_pc;
        end
    end

    assign w_frozen   = r_trap_valid;
    assign trap_valid = r_trap_valid;
    assign trap_code  = r_trap_code;
    assign trap_pc    = r_trap_pc;
`else
    logic w_unused_a0;
    assign w_unused_a0 = ^a0_value;
    assign w_frozen    = 1'b0;
    assign trap_valid  = 1'b0;
    assign trap_code   = '0;
    assign trap_pc     = '0;
`endif

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Bench for difftest_commit_queue: a 2-lane and a 1-lane output instance share stimulus,
// each checked every cycle against a queue-based reference model.
module tb_difftest_commit_queue;

    localparam int IN_CH = 2;
    localparam int DEPTH = 8;
`ifdef COMMIT_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [7:0]  wdest;
        logic        skip;
        logic [63:0] wdata;
    } ent_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]   in_valid;
    logic [127:0] in_pc;
    logic [63:0]  in_instr;
    logic [1:0]   in_wen;
    logic [15:0]  in_wdest;
    logic [127:0] in_wdata;
    logic [1:0]   in_skip;
    logic [63:0]  a0_value;

    logic         in_ready_a, in_ready_b;
    logic [1:0]   out_valid_a;
    logic [127:0] out_pc_a, out_wdata_a;
    logic [63:0]  out_instr_a;
    logic [1:0]   out_wen_a, out_skip_a;
    logic [15:0]  out_wdest_a, out_index_a;
    logic [0:0]   out_valid_b, out_wen_b, out_skip_b;
    logic [63:0]  out_pc_b, out_wdata_b;
    logic [31:0]  out_instr_b;
    logic [7:0]   out_wdest_b, out_index_b;
    logic [3:0]   occupancy_a, occupancy_b;
    logic [63:0]  instr_cnt_a, cycle_cnt_a, instr_cnt_b, cycle_cnt_b;
    logic         trap_valid_a, trap_valid_b;
    logic [63:0]  trap_code_a, trap_pc_a, trap_code_b, trap_pc_b;

    difftest_commit_queue #(.IN_CH(2), .OUT_CH(2), .DEPTH(DEPTH)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_pc(in_pc), .in_instr(in_instr), .in_wen(in_wen), .in_wdest(in_wdest),
        .in_wdata(in_wdata), .in_skip(in_skip), .out_valid(out_valid_a), .out_pc(out_pc_a),
        .out_instr(out_instr_a), .out_wen(out_wen_a), .out_wdest(out_wdest_a),
        .out_wdata(out_wdata_a), .out_skip(out_skip_a), .out_index(out_index_a),
        .occupancy(occupancy_a), .instr_cnt(instr_cnt_a), .cycle_cnt(cycle_cnt_a),
        .a0_value(a0_value), .trap_valid(trap_valid_a), .trap_code(trap_code_a),
        .trap_pc(trap_pc_a)
    );

    difftest_commit_queue #(.IN_CH(2), .OUT_CH(1), .DEPTH(DEPTH)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_pc(in_pc), .in_instr(in_instr), .in_wen(in_wen), .in_wdest(in_wdest),
        .in_wdata(in_wdata), .in_skip(in_skip), .out_valid(out_valid_b), .out_pc(out_pc_b),
        .out_instr(out_instr_b), .out_wen(out_wen_b), .out_wdest(out_wdest_b),
        .out_wdata(out_wdata_b), .out_skip(out_skip_b), .out_index(out_index_b),
        .occupancy(occupancy_b), .instr_cnt(instr_cnt_b), .cycle_cnt(cycle_cnt_b),
        .a0_value(a0_value), .trap_valid(trap_valid_b), .trap_code(trap_code_b),
        .trap_pc(trap_pc_b)
    );

    int n_checks = 0;
    int n_fails  = 0;

    ent_t        qa[$];
    ent_t        qb[$];
    bit          m_live [2];
    bit          m_trap [2];
    logic [63:0] m_icnt [2];
    logic [63:0] m_ccnt [2];
    logic [63:0] m_tcode [2];
    logic [63:0] m_tpc [2];
    int          m_nout [2];
    ent_t        m_exp [2][2];
    logic [63:0] next_pc = 64'h8000_0200;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int d = 0; d < 2; d++) begin
            m_live[d] = 0; m_trap[d] = 0; m_nout[d] = 0;
            m_icnt[d] = '0; m_ccnt[d] = '0; m_tcode[d] = '0; m_tpc[d] = '0;
            m_exp[d][0] = '0; m_exp[d][1] = '0;
        end
    endtask

    // One clock edge of the reference: commit up to oc oldest entries, then accept the group.
    task automatic model_edge(input int d, input int oc);
        bit   rdy;
        int   n;
        ent_t e;
        rdy = m_live[d] && !m_trap[d] && (DEPTH - q_size(d) >= IN_CH);
        n = 0;
        m_exp[d][0] = '0;
        m_exp[d][1] = '0;
        if (!m_trap[d]) begin
            while (n < oc && q_size(d) > 0) begin
                e = (d == 0) ? qa.pop_front() : qb.pop_front();
                m_exp[d][n] = e;
                n++;
                if (TRAP_EN && e.instr == 32'h0000_006b) begin
                    m_trap[d] = 1; m_tcode[d] = a0_value; m_tpc[d] = e.pc;
                    break;
                end
            end
            m_icnt[d] += 64'(n);
            m_ccnt[d] += 64'd1;
        end
        m_nout[d] = n;
        if (rdy) begin
            for (int i = 0; i < IN_CH; i++) begin
                if (in_valid[i]) begin
                    e.pc    = in_pc[i*64 +: 64];
                    e.instr = in_instr[i*32 +: 32];
                    e.wdest = in_wdest[i*8 +: 8];
                    e.wen   = in_wen[i] && (e.wdest != 8'd0);
                    e.skip  = in_skip[i];
                    e.wdata = in_wdata[i*64 +: 64];
                    if (d == 0) qa.push_back(e); else qb.push_back(e);
                end
            end
        end
        m_live[d] = 1;
    endtask

    task automatic compare(input int d);
        int          oc;
        ent_t        g;
        logic [7:0]  gidx;
        logic [63:0] g_vld, g_occ, g_icnt, g_ccnt, g_rdy, g_tv, g_tc, g_tp;
        bit          e_rdy;
        oc = (d == 0) ? 2 : 1;
        if (d == 0) begin
            g_vld = 64'(out_valid_a); g_occ = 64'(occupancy_a); g_icnt = instr_cnt_a;
            g_ccnt = cycle_cnt_a; g_rdy = 64'(in_ready_a); g_tv = 64'(trap_valid_a);
            g_tc = trap_code_a; g_tp = trap_pc_a;
        end else begin
            g_vld = 64'(out_valid_b); g_occ = 64'(occupancy_b); g_icnt = instr_cnt_b;
            g_ccnt = cycle_cnt_b; g_rdy = 64'(in_ready_b); g_tv = 64'(trap_valid_b);
            g_tc = trap_code_b; g_tp = trap_pc_b;
        end
        e_rdy = m_live[d] && !m_trap[d] && (DEPTH - q_size(d) >= IN_CH);
        chk($sformatf("dut%0d out_valid", d), g_vld, 64'((1 << m_nout[d]) - 1));
        for (int j = 0; j < oc; j++) begin
            if (d == 0) begin
                g = {out_pc_a[j*64 +: 64], out_instr_a[j*32 +: 32], out_wen_a[j],
                     out_wdest_a[j*8 +: 8], out_skip_a[j], out_wdata_a[j*64 +: 64]};
                gidx = out_index_a[j*8 +: 8];
            end else begin
                g = {out_pc_b, out_instr_b, out_wen_b[0], out_wdest_b, out_skip_b[0], out_wdata_b};
                gidx = out_index_b;
            end
            chk($sformatf("dut%0d lane%0d pc", d, j), g.pc, m_exp[d][j].pc);
            chk($sformatf("dut%0d lane%0d instr", d, j), 64'(g.instr), 64'(m_exp[d][j].instr));
            chk($sformatf("dut%0d lane%0d wen/wdest/skip", d, j), 64'({g.wen, g.wdest, g.skip}),
                64'({m_exp[d][j].wen, m_exp[d][j].wdest, m_exp[d][j].skip}));
            chk($sformatf("dut%0d lane%0d wdata", d, j), g.wdata, m_exp[d][j].wdata);
            chk($sformatf("dut%0d lane%0d index", d, j), 64'(gidx), 64'(j));
        end
        chk($sformatf("dut%0d occupancy", d), g_occ, 64'(q_size(d)));
        chk($sformatf("dut%0d instr_cnt", d), g_icnt, m_icnt[d]);
        chk($sformatf("dut%0d cycle_cnt", d), g_ccnt, m_ccnt[d]);
        chk($sformatf("dut%0d in_ready", d), g_rdy, 64'(e_rdy));
        chk($sformatf("dut%0d trap_valid", d), g_tv, 64'(m_trap[d]));
        chk($sformatf("dut%0d trap_code", d), g_tc, m_tcode[d]);
        chk($sformatf("dut%0d trap_pc", d), g_tp, m_tpc[d]);
    endtask

    task automatic step();
        model_edge(0, 2);
        model_edge(1, 1);
        @(posedge clock);
        #1;
        compare(0);
        compare(1);
    endtask

    task automatic clear_in();
        in_valid = '0; in_pc = '0; in_instr = '0; in_wen = '0;
        in_wdest = '0; in_wdata = '0; in_skip = '0;
    endtask

    task automatic drive_lane(input int i, input logic [63:0] pc, input logic [31:0] ins,
                              input logic wen, input logic [7:0] wd, input logic [63:0] wdat,
                              input logic sk);
        in_valid[i]          = 1'b1;
        in_pc[i*64 +: 64]    = pc;
        in_instr[i*32 +: 32] = ins;
        in_wen[i]            = wen;
        in_wdest[i*8 +: 8]   = wd;
        in_wdata[i*64 +: 64] = wdat;
        in_skip[i]           = sk;
    endtask

    task automatic drive_random(input bit both);
        logic [31:0] ins;
        clear_in();
        for (int i = 0; i < IN_CH; i++) begin
            if (both || $urandom_range(0, 1) == 1) begin
                ins = $urandom;
                if (ins == 32'h0000_006b) ins = 32'h0000_0013;
                drive_lane(i, next_pc, ins, 1'($urandom), 8'($urandom_range(0, 3)),
                           {$urandom, $urandom}, 1'($urandom));
                next_pc += 64'd4;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          max_occ_b;
        bit          saw7;
        logic [63:0] last_pc_b;
        clear_in();
        a0_value = '0;
        model_reset();

        // Reset state, then release between edges.
        repeat (3) @(posedge clock);
        #1;
        compare(0);
        compare(1);
        chk("reset in_ready", 64'(in_ready_a), 64'd0);
        @(negedge clock) reset_n = 1'b1;
        step();
        chk("in_ready after release", 64'(in_ready_a), 64'd1);

        // Full group, two cycles to the commit lanes.
        drive_lane(0, 64'h8000_0000, 32'h0000_0093, 1'b1, 8'd1, 64'h11, 1'b0);
        drive_lane(1, 64'h8000_0004, 32'h0000_0113, 1'b1, 8'd2, 64'h22, 1'b0);
        step();
        clear_in();
        step();
        chk("t1 out_valid", 64'(out_valid_a), 64'h3);
        chk("t1 lane0 pc", out_pc_a[63:0], 64'h8000_0000);
        chk("t1 instr_cnt", instr_cnt_a, 64'd2);

        // Sparse group: lane 1 alone lands on output lane 0.
        drive_lane(1, 64'h8000_0010, 32'h0000_0193, 1'b0, 8'd3, 64'h33, 1'b1);
        step();
        clear_in();
        step();
        chk("t2 out_valid", 64'(out_valid_a), 64'h1);
        chk("t2 lane0 pc", out_pc_a[63:0], 64'h8000_0010);
        chk("t2 lane0 index", 64'(out_index_a[7:0]), 64'd0);
        chk("t2 lane1 index", 64'(out_index_a[15:8]), 64'd1);

        // Write to x0 is suppressed, a real destination is not.
        drive_lane(0, 64'h8000_0020, 32'h0000_0013, 1'b1, 8'd0, 64'hdead, 1'b0);
        drive_lane(1, 64'h8000_0024, 32'h0000_0293, 1'b1, 8'd5, 64'hbeef, 1'b0);
        step();
        clear_in();
        step();
        chk("t4 x0 wen", 64'(out_wen_a[0]), 64'd0);
        chk("t4 x5 wen", 64'(out_wen_a[1]), 64'd1);

        // Randomised traffic.
        for (int c = 0; c < 300; c++) begin
            drive_random(1'b0);
            a0_value = {$urandom, $urandom};
            step();
        end
        clear_in();
        repeat (10) step();

        // Fill the single-lane drain instance and watch it wrap.
        max_occ_b = 0;
        saw7 = 0;
        for (int c = 0; c < 14; c++) begin
            drive_random(1'b1);
            step();
            if (int'(occupancy_b) > max_occ_b) max_occ_b = int'(occupancy_b);
            if (occupancy_b == 4'd7) begin
                saw7 = 1;
                chk("t3 in_ready at count 7", 64'(in_ready_b), 64'd0);
            end
        end
        chk("t3 reached count 7", 64'(saw7), 64'd1);
        chk("t3 occupancy within depth", 64'(max_occ_b <= DEPTH), 64'd1);
        clear_in();
        last_pc_b = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid_b[0]) begin
                chk("t3 drain pc order", 64'(out_pc_b > last_pc_b), 64'd1);
                last_pc_b = out_pc_b;
            end
        end

        // Asynchronous reset with five entries queued.
        for (int c = 0; c < 20 && occupancy_b != 4'd5; c++) begin
            drive_random(1'b1);
            step();
        end
        clear_in();
        chk("t4 occupancy reached 5", 64'(occupancy_b), 64'd5);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare(0);
        compare(1);
        chk("t4 async occupancy", 64'(occupancy_b), 64'd0);
        chk("t4 async out_valid", 64'(out_valid_b), 64'd0);
        @(negedge clock) reset_n = 1'b1;
        #1;
        chk("t4 in_ready before first edge", 64'(in_ready_b), 64'd0);
        step();
        chk("t4 in_ready one cycle after release", 64'(in_ready_b), 64'd1);

        // Good trap in lane 0 with a follower in lane 1.
        a0_value = '0;
        drive_lane(0, 64'h8000_0100, 32'h0000_006b, 1'b0, 8'd0, 64'h0, 1'b0);
        drive_lane(1, 64'h8000_0104, 32'h0000_0013, 1'b1, 8'd6, 64'h66, 1'b0);
        step();
        clear_in();
        step();
`ifdef COMMIT_TRAP_EN
        chk("t5 out_valid", 64'(out_valid_a), 64'h1);
        chk("t5 trap_valid", 64'(trap_valid_a), 64'd1);
        chk("t5 trap_code", trap_code_a, 64'd0);
        chk("t5 trap_pc", trap_pc_a, 64'h8000_0100);
        chk("t5 instr_cnt", instr_cnt_a, 64'd1);
`else
        chk("t6 out_valid", 64'(out_valid_a), 64'h3);
        chk("t6 trap_valid", 64'(trap_valid_a), 64'd0);
        chk("t6 instr_cnt", instr_cnt_a, 64'd2);
`endif
        for (int c = 0; c < 4; c++) begin
            drive_random(1'b1);
            step();
        end
        clear_in();
`ifdef COMMIT_TRAP_EN
        chk("t5 frozen in_ready", 64'(in_ready_a), 64'd0);
        chk("t5 frozen instr_cnt", instr_cnt_a, 64'd1);
`else
        chk("t6 trap_valid stays low", 64'(trap_valid_a), 64'd0);
        chk("t6 in_ready", 64'(in_ready_a), 64'd1);
`endif
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
